crc_byte_serializer: RTL

Byte-to-bit front end for the bit-serial CRC generator. It accepts message bytes over a valid/ready stream with a last-byte marker and produces the generator's per-frame sync reset pulse, its data bit and its enable strobe. It signals when the CRC output is final. It sits directly upstream of the CRC generator, one instance per CRC engine.

---
 rtl/crc_byte_serializer_pkg.sv | 17 +
 rtl/crc_byte_serializer_if.sv | 32 +++
 rtl/crc_byte_serializer_bit_shifter.sv | 52 +++++
 rtl/crc_byte_serializer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/crc_byte_serializer_pkg.sv
// crc_pkg: shared types for the CRC byte serializer slice.
//   state_t        - serializer FSM states (IDLE, INIT, SHIFT, STALL, DONE)
//   DEFAULT_DATA_W - default message word width in bits
// No ports; imported by the interface, the bit shifter and the top level.
package crc_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    STALL,
    DONE
  } state_t;

endpackage

// File: rtl/crc_byte_serializer_if.sv
// crc_byte_serializer_if: valid/ready word stream feeding the serializer.
//   in_data  - message word (DATA_W bits)
//   in_valid - in_data/in_last valid
//   in_last  - word is the final word of the frame
//   in_ready - word accepted on clk rise when in_valid & in_ready
// Modports: master (word producer), slave (serializer).
interface crc_byte_serializer_if
  import crc_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/crc_byte_serializer_bit_shifter.sv
// crc_bit_shifter: parallel-load shift register that presents one message
// bit per advance, MSB first or LSB first (LSB_FIRST), with a bit counter.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - capture load_data/load_last, restart the bit counter
//   advance     - move on to the next bit of the current word
//   load_data   - word to serialize
//   load_last   - word is the last of its frame
//   bit_out     - bit currently presented
//   last_bit    - bit_out is the final bit of the word (bit_cnt == DATA_W-1)
//   word_last   - the word in the shifter is the last of its frame
module crc_bit_shifter #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              bit_out,
  output logic              last_bit,
  output logic              word_last
);

  localparam int                CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  // Shifting toward the output end keeps the presented bit at a fixed
  // position, which is the same as indexing by bit_cnt from that end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      word_last <= 1'b0;
    end else if (load) begin
      shreg     <= load_data;
      bit_cnt   <= '0;
      word_last <= load_last;
    end else if (advance) begin
      shreg   <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
      bit_cnt <= (bit_cnt == CNT_MAX) ? '0 : bit_cnt + 1'b1;
    end
  end

  assign bit_out  = LSB_FIRST ? shreg[0] : shreg[DATA_W-1];
  assign last_bit = (bit_cnt == CNT_MAX);

endmodule

// File: rtl/crc_byte_serializer.sv
// crc_byte_serializer: byte-to-bit front end for a bit-serial CRC generator.
// Accepts words on a valid/ready stream and drives the generator's per-frame
// sync reset (crc_rst), data bit (crc_data) and enable (crc_en); frame_done
// pulses when the CRC output is final.
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_bus      - crc_byte_serializer_if.slave word stream
//   crc_rst     - one-cycle sync reset to the CRC generator at frame start
//   crc_data    - message bit to the CRC generator
//   crc_en      - CRC generator accepts crc_data this cycle
//   frame_done  - one-cycle pulse, CRC output final for the frame
//   busy        - frame in progress
// Optional (macro CRC_BYTE_SERIALIZER_STATS_EN): frame_cnt and word_cnt
// wrapping 16-bit counters of completed frames and accepted words.
module crc_byte_serializer
  import crc_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  crc_byte_serializer_if.slave        in_bus,
  output logic                        crc_rst,
  output logic                        crc_data,
  output logic                        crc_en,
  output logic                        frame_done,
  output logic                        busy
`ifdef CRC_BYTE_SERIALIZER_STATS_EN
  ,
  output logic [15:0]                 frame_cnt,
  output logic [15:0]                 word_cnt
`endif
);

  state_t            state, next_state;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  logic              hold_valid;
  logic              last_seen;
  logic              ready_en;
  logic              ready_ok;
  logic              ready;
  logic              accept;
  logic              drain;
  logic              shift_advance;
  logic              bit_out;
  logic              last_bit;
  logic              word_last;

  crc_bit_shifter #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (drain),
    .advance  (shift_advance),
    .load_data(hold_data),
    .load_last(hold_last),
    .bit_out  (bit_out),
    .last_bit (last_bit),
    .word_last(word_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A non-last word whose successor is already held reloads without a gap
  // cycle; only an empty hold sends the FSM to STALL.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept) next_state = INIT;
      INIT:  next_state = SHIFT;
      SHIFT: begin
        if (last_bit) begin
          if (word_last) begin
            next_state = DONE;
          end else if (!hold_valid) begin
            next_state = STALL;
          end
        end
      end
      STALL: if (hold_valid) next_state = SHIFT;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // drain marks the cycle the hold register moves into the shifter, which
  // frees the hold for a new word in that same cycle.
  always_comb begin
    crc_rst    = 1'b0;
    crc_en     = 1'b0;
    frame_done = 1'b0;
    drain      = 1'b0;
    ready_ok   = 1'b0;
    unique case (state)
      IDLE:  ready_ok = 1'b1;
      INIT: begin
        crc_rst  = 1'b1;
        drain    = 1'b1;
        ready_ok = 1'b1;
      end
      SHIFT: begin
        crc_en   = 1'b1;
        drain    = last_bit & ~word_last & hold_valid;
        ready_ok = ~hold_valid | drain;
      end
      STALL: begin
        drain    = hold_valid;
        ready_ok = ~hold_valid | drain;
      end
      DONE:  frame_done = 1'b1;
      default: ;
    endcase
    ready         = ready_en & ~last_seen & ready_ok;
    accept        = in_bus.in_valid & ready;
    shift_advance = crc_en & ~drain;
    crc_data      = crc_en & bit_out;
    busy          = (state != IDLE);
  end

  assign in_bus.in_ready = ready;

  // ready_en keeps in_ready low while reset is asserted even though the
  // state register already reads IDLE. last_seen blocks the next frame's
  // words until the current frame has fully drained back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_valid <= 1'b0;
      last_seen  <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        hold_data  <= in_bus.in_data;
        hold_last  <= in_bus.in_last;
        hold_valid <= 1'b1;
      end else if (drain) begin
        hold_valid <= 1'b0;
      end
      if (state == DONE) begin
        last_seen <= 1'b0;
      end else if (accept && in_bus.in_last) begin
        last_seen <= 1'b1;
      end
    end
  end

`ifdef CRC_BYTE_SERIALIZER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (accept)     word_cnt  <= word_cnt + 16'd1;
    end
  end
`endif

endmodule
